// File: rtl/plot_arbiter_if.sv
// rtl/plot_arbiter_if.sv - request/grant and VGA pixel bundle for plot_arbiter
//
// Purpose: groups the four requesters' pixel requests, the clear pulse and the
// serialised pixel-write port toward the VGA adapter.
// Ports (signals):
//   req[3:0]          per-requester request, bit 0 = player
//   req_x[31:0]       four packed 8-bit columns, requester i in [8i+7:8i]
//   req_y[27:0]       four packed 7-bit rows, requester i in [7i+6:7i]
//   req_colour[11:0]  four packed 3-bit colours, requester i in [3i+2:3i]
//   clear             one-cycle pulse requesting a full-screen clear
//   grant[3:0]        one-hot pulse, requester's pixel consumed
//   x, y, colour      pixel toward the VGA adapter
//   writeEn           VGA write strobe
//   oob               pulse: granted pixel was out of range and dropped
//   busy              high while a clear sweep runs
// Modports: slave = arbiter side, master = requester / adapter side.
interface plot_arbiter_if;
  logic [3:0]  req;
  logic [31:0] req_x;
  logic [27:0] req_y;
  logic [11:0] req_colour;
  logic        clear;
  logic [3:0]  grant;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [2:0]  colour;
  logic        writeEn;
  logic        oob;
  logic        busy;

  modport slave (
    input  req, req_x, req_y, req_colour, clear,
    output grant, x, y, colour, writeEn, oob, busy
  );

  modport master (
    output req, req_x, req_y, req_colour, clear,
    input  grant, x, y, colour, writeEn, oob, busy
  );
endinterface

// File: rtl/plot_arbiter.sv
// rtl/plot_arbiter.sv - round-robin arbiter for the VGA pixel-write port
//
// Purpose: serialises four pixel requesters onto one VGA write port, one pixel
// per two cycles, round-robin starting after the last winner. With the
// PLOT_CLEAR_EN macro defined, a clear engine sweeps the 160x120 frame to
// BG_COLOUR one pixel per cycle and takes priority over every requester.
// Without it, clear is ignored and busy is tied low.
// Ports:
//   clock    system clock, rising edge
//   reset_n  asynchronous reset, active HIGH (1 = reset)
//   bus      plot_arbiter_if.slave (requests, clear, pixel port, grant, oob, busy)
module plot_arbiter #(
  parameter logic [2:0] BG_COLOUR = 3'b000,
  parameter logic [7:0] X_MAX     = 8'd159,
  parameter logic [6:0] Y_MAX     = 7'd119
) (
  input logic           clock,
  input logic           reset_n,
  plot_arbiter_if.slave bus
);

`ifdef PLOT_CLEAR_EN
  typedef enum logic [1:0] {IDLE, WRITE, CLEAR} state_t;
`else
  typedef enum logic {IDLE, WRITE} state_t;
`endif

  state_t     state_q, state_d;
  logic [1:0] last_q, last_d;
  logic [7:0] x_q, x_d;
  logic [6:0] y_q, y_d;
  logic [2:0] colour_q, colour_d;
  logic       we_q, we_d;
  logic [3:0] grant_q, grant_d;
  logic       oob_q, oob_d;

  logic [1:0] idx;
  logic [1:0] win;
  logic       found;

`ifdef PLOT_CLEAR_EN
  logic       pending_q, pending_d;
  logic [7:0] cx_q, cx_d;
  logic [6:0] cy_q, cy_d;
  logic       busy_q, busy_d;
`endif

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    x_d      = x_q;
    y_d      = y_q;
    colour_d = colour_q;
    we_d     = 1'b0;
    grant_d  = 4'b0000;
    oob_d    = 1'b0;
    idx      = 2'd0;
    win      = last_q;
    found    = 1'b0;
`ifdef PLOT_CLEAR_EN
    pending_d = pending_q;
    cx_d      = cx_q;
    cy_d      = cy_q;
    busy_d    = busy_q;
`endif

    // Search last+1, last+2, last+3, last (wraps mod 4); first hit wins.
    for (int i = 1; i <= 4; i++) begin
      idx = last_q + 2'(i);
      if (!found && bus.req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
`ifdef PLOT_CLEAR_EN
        // A clear arriving this cycle is treated as already pending so it
        // beats a simultaneous request.
        if (pending_q || bus.clear) begin
          state_d   = CLEAR;
          pending_d = 1'b0;
          cx_d      = 8'd0;
          cy_d      = 7'd0;
          x_d       = 8'd0;
          y_d       = 7'd0;
          colour_d  = BG_COLOUR;
          we_d      = 1'b1;
          busy_d    = 1'b1;
        end else
`endif
        if (found) begin
          state_d  = WRITE;
          last_d   = win;
          x_d      = bus.req_x[8*win +: 8];
          y_d      = bus.req_y[7*win +: 7];
          colour_d = bus.req_colour[3*win +: 3];
          grant_d  = 4'b0001 << win;
          if (x_d <= X_MAX && y_d <= Y_MAX) we_d = 1'b1;
          else oob_d = 1'b1;
        end
      end
      WRITE: begin
        state_d = IDLE;
`ifdef PLOT_CLEAR_EN
        if (bus.clear) pending_d = 1'b1;
`endif
      end
`ifdef PLOT_CLEAR_EN
      CLEAR: begin
        // Counters track the pixel currently on the outputs; clear pulses
        // here are ignored so the sweep is never restarted.
        if (cx_q == X_MAX && cy_q == Y_MAX) begin
          state_d = IDLE;
          cx_d    = 8'd0;
          cy_d    = 7'd0;
          busy_d  = 1'b0;
        end else begin
          if (cx_q == X_MAX) begin
            cx_d = 8'd0;
            cy_d = cy_q + 7'd1;
          end else begin
            cx_d = cx_q + 8'd1;
          end
          x_d      = cx_d;
          y_d      = cy_d;
          colour_d = BG_COLOUR;
          we_d     = 1'b1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset_n) begin
    if (reset_n) begin
      state_q  <= IDLE;
      last_q   <= 2'd3;
      x_q      <= 8'd0;
      y_q      <= 7'd0;
      colour_q <= 3'd0;
      we_q     <= 1'b0;
      grant_q  <= 4'd0;
      oob_q    <= 1'b0;
`ifdef PLOT_CLEAR_EN
      pending_q <= 1'b0;
      cx_q      <= 8'd0;
      cy_q      <= 7'd0;
      busy_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      x_q      <= x_d;
      y_q      <= y_d;
      colour_q <= colour_d;
      we_q     <= we_d;
      grant_q  <= grant_d;
      oob_q    <= oob_d;
`ifdef PLOT_CLEAR_EN
      pending_q <= pending_d;
      cx_q      <= cx_d;
      cy_q      <= cy_d;
      busy_q    <= busy_d;
`endif
    end
  end

  assign bus.x       = x_q;
  assign bus.y       = y_q;
  assign bus.colour  = colour_q;
  assign bus.writeEn = we_q;
  assign bus.grant   = grant_q;
  assign bus.oob     = oob_q;
`ifdef PLOT_CLEAR_EN
  assign bus.busy    = busy_q;
`else
  logic unused_clear;
  assign unused_clear = bus.clear;
  assign bus.busy     = 1'b0;
`endif

endmodule

// File: tb/tb_plot_arbiter.sv
// tb/tb_plot_arbiter.sv - scoreboard testbench for plot_arbiter
module tb_plot_arbiter;
  logic clock   = 1'b0;
  logic reset_n = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;

  plot_arbiter_if bus();

  plot_arbiter dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [3:0] grant;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       we;
    logic       oob;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  int         grant_cyc       = 0;
  int         busy_fall_cyc   = 0;
  int         clear_writes    = 0;
  int         clear_order_err = 0;
  int         rr_gap_err      = 0;
  int         rr_prev         = -1;
  bit         rr_mode         = 0;
  bit         busy_seen       = 0;
  logic       busy_prev       = 1'b0;
  logic [7:0] exp_cx = 8'd0;
  logic [6:0] exp_cy = 7'd0;
  logic [7:0] last_cx = 8'd0;
  logic [6:0] last_cy = 7'd0;
  logic [2:0] last_cc = 3'd0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, want);
  endtask

  // Output monitor: pops the scoreboard on every grant, tracks the clear sweep.
  always @(negedge clock) begin
    if (!reset_n) begin
      if (bus.busy) busy_seen = 1;
      if (bus.grant != 4'b0000) begin
        grant_cyc = cyc;
        if (rr_mode) begin
          if (rr_prev >= 0 && cyc - rr_prev != 2) rr_gap_err++;
          rr_prev = cyc;
        end
        if (bus.busy) check("grant_during_busy", 32'(bus.busy), 0);
        if (exp_q.size() == 0) begin
          check("unexpected_grant", 32'(bus.grant), 0);
        end else begin
          mon_e = exp_q.pop_front();
          check("grant",   32'(bus.grant),   32'(mon_e.grant));
          check("x",       32'(bus.x),       32'(mon_e.x));
          check("y",       32'(bus.y),       32'(mon_e.y));
          check("colour",  32'(bus.colour),  32'(mon_e.colour));
          check("writeEn", 32'(bus.writeEn), 32'(mon_e.we));
          check("oob",     32'(bus.oob),     32'(mon_e.oob));
        end
      end else if (!bus.busy && (bus.writeEn || bus.oob)) begin
        check("stray_strobe", 32'({bus.writeEn, bus.oob}), 0);
      end
      if (bus.busy && !busy_prev) begin
        exp_cx = 8'd0;
        exp_cy = 7'd0;
      end
      if (bus.busy && bus.writeEn) begin
        if (bus.x !== exp_cx || bus.y !== exp_cy || bus.colour !== 3'b000) clear_order_err++;
        clear_writes++;
        last_cx = bus.x;
        last_cy = bus.y;
        last_cc = bus.colour;
        if (exp_cx == 8'd159) begin
          exp_cx = 8'd0;
          exp_cy = exp_cy + 7'd1;
        end else begin
          exp_cx = exp_cx + 8'd1;
        end
      end
      if (busy_prev && !bus.busy) busy_fall_cyc = cyc;
      busy_prev = bus.busy;
    end else begin
      busy_prev = 1'b0;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic set_px(input int i, input logic [7:0] px, input logic [6:0] py, input logic [2:0] pc);
    bus.req_x[8*i +: 8]      = px;
    bus.req_y[7*i +: 7]      = py;
    bus.req_colour[3*i +: 3] = pc;
  endtask

  task automatic push_px(input int i, input logic [7:0] px, input logic [6:0] py, input logic [2:0] pc);
    exp_t e;
    e.grant  = 4'(1 << i);
    e.x      = px;
    e.y      = py;
    e.colour = pc;
    e.oob    = (px > 8'd159) || (py > 7'd119);
    e.we     = !e.oob;
    exp_q.push_back(e);
  endtask

  // Returns one cycle after grant[i] was seen, so the caller drops req there.
  task automatic wait_grant(input int i, input string tag);
    bit seen;
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      tick(1);
      if (bus.grant[i]) begin
        seen = 1;
        break;
      end
    end
    if (!seen) check(tag, 0, 1);
    tick(1);
  endtask

  task automatic wait_drain(input string tag);
    for (int k = 0; k < 40; k++) begin
      if (exp_q.size() == 0) break;
      tick(1);
    end
    check(tag, exp_q.size(), 0);
  endtask

  task automatic do_reset();
    reset_n = 1'b1;
    exp_q.delete();
    tick(2);
    reset_n = 1'b0;
    tick(1);
  endtask

  typedef struct { int i; int px; int py; int pc; } oob_vec_t;
  oob_vec_t oob_tab[5] = '{
    '{2, 160,  10, 5},
    '{2, 159, 119, 6},
    '{1,   0, 120, 3},
    '{3, 255, 127, 2},
    '{0,   0,   0, 1}
  };

  initial begin
    int ri, rx, ry, rc;
    bus.req        = 4'b0000;
    bus.req_x      = 32'd0;
    bus.req_y      = 28'd0;
    bus.req_colour = 12'd0;
    bus.clear      = 1'b0;
    tick(3);
    check("reset_outputs", 32'({bus.grant, bus.x, bus.y, bus.colour, bus.writeEn, bus.oob, bus.busy}), 0);
    reset_n = 1'b0;
    tick(1);

    // Single player pixel, one-cycle latency.
    set_px(0, 8'd5, 7'd5, 3'd7);
    push_px(0, 8'd5, 7'd5, 3'd7);
    bus.req = 4'b0001;
    tick(1);
    check("t1_latency_grant", 32'(bus.grant), 1);
    check("t1_writeEn", 32'(bus.writeEn), 1);
    tick(1);
    bus.req = 4'b0000;
    check("t1_back_idle", 32'(bus.grant), 0);
    wait_drain("t1_drain");

    // All four held: rotation 0,1,2,3,0,1,2,3 every second cycle.
    do_reset();
    for (int i = 0; i < 4; i++) set_px(i, 8'(10 + i), 7'(20 + i), 3'(i + 1));
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 4; i++) push_px(i, 8'(10 + i), 7'(20 + i), 3'(i + 1));
    rr_mode = 1;
    rr_prev = -1;
    bus.req = 4'b1111;
    tick(16);
    bus.req = 4'b0000;
    tick(2);
    rr_mode = 0;
    wait_drain("t2_drain");
    check("t2_gap", rr_gap_err, 0);

    // Range boundaries, single requesters.
    foreach (oob_tab[n]) begin
      set_px(oob_tab[n].i, 8'(oob_tab[n].px), 7'(oob_tab[n].py), 3'(oob_tab[n].pc));
      push_px(oob_tab[n].i, 8'(oob_tab[n].px), 7'(oob_tab[n].py), 3'(oob_tab[n].pc));
      bus.req = 4'(1 << oob_tab[n].i);
      wait_grant(oob_tab[n].i, "t3_grant_timeout");
      bus.req = 4'b0000;
    end
    wait_drain("t3_drain");

    // Contention after last=0: requester 2 before 0.
    set_px(0, 8'd40, 7'd41, 3'd2);
    set_px(2, 8'd42, 7'd43, 3'd4);
    push_px(2, 8'd42, 7'd43, 3'd4);
    push_px(0, 8'd40, 7'd41, 3'd2);
    bus.req = 4'b0101;
    wait_grant(2, "t4_grant2_timeout");
    bus.req[2] = 1'b0;
    wait_grant(0, "t4_grant0_timeout");
    bus.req[0] = 1'b0;
    wait_drain("t4_drain");

    // Random single-requester pixels.
    for (int n = 0; n < 6; n++) begin
      ri = int'($urandom_range(3, 0));
      rx = int'($urandom_range(175, 0));
      ry = int'($urandom_range(127, 0));
      rc = int'($urandom_range(7, 0));
      set_px(ri, 8'(rx), 7'(ry), 3'(rc));
      push_px(ri, 8'(rx), 7'(ry), 3'(rc));
      bus.req = 4'(1 << ri);
      wait_grant(ri, "t5_grant_timeout");
      bus.req = 4'b0000;
    end
    wait_drain("t5_drain");

`ifdef PLOT_CLEAR_EN
    // Full clear, request arriving mid-sweep waits until busy falls.
    clear_writes    = 0;
    clear_order_err = 0;
    bus.clear = 1'b1;
    tick(1);
    bus.clear = 1'b0;
    check("clr_busy_rise", 32'(bus.busy), 1);
    check("clr_first_px", 32'({bus.x, bus.y, bus.writeEn}), 1);
    tick(9);
    set_px(1, 8'd77, 7'd66, 3'd5);
    push_px(1, 8'd77, 7'd66, 3'd5);
    bus.req = 4'b0010;
    for (int k = 0; k < 20000; k++) begin
      tick(1);
      if (!bus.busy) break;
    end
    check("clr_busy_fall", 32'(bus.busy), 0);
    wait_grant(1, "clr_req_grant_timeout");
    bus.req = 4'b0000;
    wait_drain("clr_drain");
    check("clr_grant_after_busy", grant_cyc - busy_fall_cyc, 1);
    check("clr_writes", clear_writes, 19200);
    check("clr_order", clear_order_err, 0);
    check("clr_last_x", 32'(last_cx), 159);
    check("clr_last_y", 32'(last_cy), 119);
    check("clr_last_colour", 32'(last_cc), 0);

    // Second pulse mid-sweep is ignored.
    clear_writes    = 0;
    clear_order_err = 0;
    bus.clear = 1'b1;
    tick(1);
    bus.clear = 1'b0;
    tick(5000);
    bus.clear = 1'b1;
    tick(1);
    bus.clear = 1'b0;
    for (int k = 0; k < 20000; k++) begin
      tick(1);
      if (!bus.busy) break;
    end
    tick(5);
    check("clr2_no_restart", 32'(bus.busy), 0);
    check("clr2_writes", clear_writes, 19200);
    check("clr2_order", clear_order_err, 0);

    // Asynchronous reset mid-clear.
    bus.clear = 1'b1;
    tick(1);
    bus.clear = 1'b0;
    tick(100);
`else
    // Clear ignored: request served at once, busy never rises.
    set_px(1, 8'd77, 7'd66, 3'd5);
    push_px(1, 8'd77, 7'd66, 3'd5);
    bus.clear = 1'b1;
    bus.req   = 4'b0010;
    tick(1);
    bus.clear = 1'b0;
    check("noclr_grant", 32'(bus.grant), 2);
    tick(1);
    bus.req = 4'b0000;
    wait_drain("noclr_drain");
    check("noclr_busy_never", 32'(busy_seen), 0);

    // Asynchronous reset mid-write.
    set_px(0, 8'd9, 7'd9, 3'd3);
    bus.req = 4'b0001;
    tick(1);
    bus.req = 4'b0000;
`endif
    #3;
    reset_n = 1'b1;
    exp_q.delete();
    #1;
    check("async_reset_outputs", 32'({bus.grant, bus.x, bus.y, bus.colour, bus.writeEn, bus.oob, bus.busy}), 0);
    tick(2);
    reset_n = 1'b0;
    tick(1);
    for (int i = 0; i < 4; i++) set_px(i, 8'(100 + i), 7'(50 + i), 3'(7 - i));
    push_px(0, 8'd100, 7'd50, 3'd7);
    bus.req = 4'b1111;
    wait_grant(0, "post_reset_grant_timeout");
    bus.req = 4'b0000;
    wait_drain("post_reset_drain");
    check("post_reset_busy", 32'(bus.busy), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/plot_arbiter.md
# plot_arbiter

Shares the single pixel-write port of the VGA adapter among four pixel requesters: the player draw controller, two sprite controllers and the score overlay. Each requester presents one pixel (x, y, colour) with a req/grant handshake; the arbiter serialises them round-robin onto x, y, colour and writeEn. An optional clear engine sweeps the 160x120 frame to background colour, taking priority over all requesters. The block sits between the draw controllers and the VGA adapter instance in the top level.

## Interface
- BG_COLOUR, 3'b000, colour written by the clear engine
- X_MAX, 159, last valid column
- Y_MAX, 119, last valid row
- clock  in  1  system clock; all state on rising edge
- reset_n  in  1  asynchronous, active-high reset; despite the name, 1 = reset
- req  in  4  per-requester pixel request; bit 0 = player
- req_x  in  32  four packed 8-bit x coordinates; requester i in bits [8i+7:8i]
- req_y  in  28  four packed 7-bit y coordinates; requester i in bits [7i+6:7i]
- req_colour  in  12  four packed 3-bit colours; requester i in bits [3i+2:3i]
- clear  in  1  one-cycle pulse that starts a full-screen clear
- grant  out  4  one-hot, one-cycle pulse: requester's pixel consumed
- x  out  8  pixel column to VGA adapter
- y  out  7  pixel row to VGA adapter
- colour  out  3  pixel colour to VGA adapter
- writeEn  out  1  VGA write strobe
- oob  out  1  one-cycle pulse: granted pixel was out of range and was dropped
- busy  out  1  high while a clear is in progress

## Operation
- States: IDLE, WRITE, CLEAR.
- IDLE: if a clear is pending, go to CLEAR. Otherwise, if any req bit is set, choose the winner round-robin, latch its x/y/colour into the output registers and go to WRITE. If no req bit is set, stay in IDLE.
- Round-robin: the search starts at (last + 1) mod 4. The `last` register updates to the winner on every grant. Reset value of `last` is 3, so requester 0 wins first.
- WRITE (exactly one cycle): grant[winner]=1.
  - If latched x ≤ X_MAX and y ≤ Y_MAX: writeEn=1.
  - Otherwise: writeEn=0 and oob=1.
  - Next state is always IDLE.
- Requester rule: hold req, x, y and colour stable until grant is seen; drop or advance req on the edge after grant.
- Throughput: 1 pixel per 2 cycles, so a req re-sampled in IDLE is always fresh.
- CLEAR: writes rows 0..Y_MAX, with columns 0..X_MAX inside each row, one pixel per cycle. writeEn=1, colour=BG_COLOUR, busy=1. After pixel (X_MAX, Y_MAX) is written, go to IDLE with the counters zeroed.
- clear pulse behaviour:
  - Arriving in IDLE: sets the pending flag.
  - Arriving in WRITE: sets the pending flag; the clear starts after the write completes.
  - Arriving in CLEAR: ignored; does not restart the sweep.
- Requests arriving during CLEAR wait and receive no grant.
- No grant is ever issued while busy=1.
- Reset: all outputs 0, state IDLE, clear counters 0, pending flag 0, last=3. A reset mid-clear abandons the sweep.

## Timing
- Request sampled in IDLE at edge N. At edge N+1, the registered x/y/colour/writeEn/grant become valid for the whole of cycle N+1. Latency: 1 cycle.
- grant and oob are high for exactly one cycle and never overlap with CLEAR.
- With a pending clear and a simultaneous req in IDLE, the clear wins.
- The clear edge moves the FSM to CLEAR. Pixel (0,0) is written the cycle after that edge. The full clear takes 19200 writeEn cycles, and busy falls in the cycle after the last pixel.
- With all four req bits held high, grants rotate 0,1,2,3,0 on every second cycle.

## Configuration
- PLOT_CLEAR_EN defined: clear engine, CLEAR state and busy are present as described above.
- PLOT_CLEAR_EN undefined:
  - clear input is ignored and busy is tied 0.
  - No CLEAR state or sweep counters exist.
  - The FSM is IDLE/WRITE only.

## Test plan
- Reset, then req=4'b0001 with x=5, y=5, colour=3'b111 → after 1 cycle: grant=0001, writeEn=1, x=5, y=5, colour=7; then IDLE.
- req=4'b1111 held for 16 cycles → grant sequence 0,1,2,3,0,1,2,3 at 2-cycle spacing, each with that requester's coordinates.
- req[2] with x=160, y=10 → grant=0100, oob=1, writeEn=0 for one cycle.
- clear pulse, then req[1] asserted 10 cycles later → busy=1, exactly 19200 writeEn cycles, last pixel (159,119) with colour BG_COLOUR; grant[1] comes 1 cycle after busy falls.
- Second clear pulse at cycle 5000 of a clear → ignored; total is still 19200 writes.
- reset_n=1 mid-clear → all outputs 0 immediately (asynchronous); after release, req[0] is granted first.
